// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage CPU pipeline control:
// register-address width, scoreboard entry layout and counter helpers.
package cpu_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int SB_DEPTH   = 3;
    localparam int CNT_W      = 16;

    // One in-flight destination: slot occupied, writes a register, which one.
    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic [REG_ADDR_W-1:0] waddr;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, wen: 1'b0, waddr: {REG_ADDR_W{1'b0}}};

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sb_match.sv
// Compares one ID-stage source register against every scoreboard entry
// and flags a read-after-write hazard.
module sb_match
    import cpu_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1,
    parameter bit R0_ZERO   = 1'b1
) (
    input  logic                            i_src_used,
    input  logic [REG_ADDR_W-1:0]           i_src_addr,
    input  sb_entry_t [SB_DEPTH-1:0]        i_sb,
    output logic                            o_hazard
);

    logic w_hit;
    logic w_src_live;

    // Look for a pending writer of the source; the oldest (WB) slot is
    // skipped when the register file forwards same-cycle writes.
    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            if (i_sb[k].valid && i_sb[k].wen && (i_sb[k].waddr == i_src_addr) &&
                ((k != (SB_DEPTH - 1)) || !WB_BYPASS)) begin
                w_hit = 1'b1;
            end else begin
                w_hit = w_hit;
            end
        end
    end

    // A source only matters if it is read and is not the hard-wired zero register.
    always_comb begin
        w_src_live = i_src_used;
        if (R0_ZERO && (i_src_addr == {REG_ADDR_W{1'b0}})) begin
            w_src_live = 1'b0;
        end else begin
            w_src_live = i_src_used;
        end
    end

    assign o_hazard = w_src_live & w_hit;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock and flush controller: tracks in-flight destinations,
// stalls IF/ID on RAW hazards, squashes wrong-path work on taken branches
// and drains the pipeline on a debug halt.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1,
    parameter bit R0_ZERO   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_raddr1,
    input  logic        id_raddr1_used,
    input  logic [3:0]  id_raddr2,
    input  logic        id_raddr2_used,
    input  logic        id_reg_wen,
    input  logic [3:0]  id_waddr,
    input  logic        branch_taken,
    input  logic        dbg_halt,
    output logic        pc_wen,
    output logic        ifid_wen,
    output logic        ifid_flush,
    output logic        idexe_bubble,
    output logic        stall,
    output logic        halted,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    sb_entry_t                r_sb_exe;
    sb_entry_t                r_sb_mem;
    sb_entry_t                r_sb_wb;
    sb_entry_t [SB_DEPTH-1:0] w_sb;
    logic                     w_hazard1;
    logic                     w_hazard2;
    logic                     w_stall;
    logic                     w_issue;
    logic [CNT_W-1:0]         r_stall_cycles;
    logic [CNT_W-1:0]         r_flush_events;

    // Index 0 is the youngest (EXE) entry, index 2 the oldest (WB).
    assign w_sb = {r_sb_wb, r_sb_mem, r_sb_exe};

    sb_match #(.WB_BYPASS(WB_BYPASS), .R0_ZERO(R0_ZERO)) u_match1 (
        .i_src_used (id_raddr1_used),
        .i_src_addr (id_raddr1),
        .i_sb       (w_sb),
        .o_hazard   (w_hazard1)
    );

    sb_match #(.WB_BYPASS(WB_BYPASS), .R0_ZERO(R0_ZERO)) u_match2 (
        .i_src_used (id_raddr2_used),
        .i_src_addr (id_raddr2),
        .i_sb       (w_sb),
        .o_hazard   (w_hazard2)
    );

    // A taken branch kills the ID instruction, so it can never be stalled.
    assign w_stall = id_valid & (w_hazard1 | w_hazard2) & ~branch_taken;
    assign w_issue = id_valid & ~w_stall & ~branch_taken & ~dbg_halt;

    assign stall        = w_stall;
    assign halted       = dbg_halt & ~r_sb_exe.valid & ~r_sb_mem.valid & ~r_sb_wb.valid;
    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

    // Pipeline register controls in priority order: reset, branch, hold, run.
    always_comb begin
        pc_wen       = 1'b1;
        ifid_wen     = 1'b1;
        ifid_flush   = 1'b0;
        idexe_bubble = 1'b0;
        if (rst) begin
            pc_wen       = 1'b0;
            ifid_wen     = 1'b0;
            ifid_flush   = 1'b1;
            idexe_bubble = 1'b1;
        end else if (branch_taken) begin
            // IF/ID must load so the flush NOP actually lands there.
            pc_wen       = 1'b1;
            ifid_wen     = 1'b1;
            ifid_flush   = 1'b1;
            idexe_bubble = 1'b1;
        end else if (w_stall || dbg_halt) begin
            pc_wen       = 1'b0;
            ifid_wen     = 1'b0;
            ifid_flush   = 1'b0;
            idexe_bubble = 1'b1;
        end else begin
            pc_wen       = 1'b1;
            ifid_wen     = 1'b1;
            ifid_flush   = 1'b0;
            idexe_bubble = 1'b0;
        end
    end

    // Scoreboard shift: issued instructions enter EXE, bubbles enter as empty slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb_exe <= SB_EMPTY;
            r_sb_mem <= SB_EMPTY;
            r_sb_wb  <= SB_EMPTY;
        end else begin
            r_sb_wb  <= r_sb_mem;
            r_sb_mem <= r_sb_exe;
            if (w_issue) begin
                r_sb_exe <= '{valid: 1'b1, wen: id_reg_wen, waddr: id_waddr};
            end else begin
                r_sb_exe <= SB_EMPTY;
            end
        end
    end

    // Saturating event counters for stall cycles and branch flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= {CNT_W{1'b0}};
            r_flush_events <= {CNT_W{1'b0}};
        end else begin
            if (w_stall) begin
                r_stall_cycles <= sat_inc(r_stall_cycles);
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
            if (branch_taken) begin
                r_flush_events <= sat_inc(r_flush_events);
            end else begin
                r_flush_events <= r_flush_events;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (WB bypass on and off)
// are driven by independent threads; each checked cycle pushes the
// hand-computed response into a queue popped by a common monitor.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       id_valid;
        logic [3:0] raddr1;
        logic       used1;
        logic [3:0] raddr2;
        logic       used2;
        logic       wen;
        logic [3:0] waddr;
        logic       bt;
        logic       halt;
    } in_t;

    typedef struct {
        string       name;
        logic [5:0]  flags;
        logic [15:0] sc;
        logic [15:0] fe;
    } exp_t;

    // flags = {stall, pc_wen, ifid_wen, ifid_flush, idexe_bubble, halted}
    localparam logic [5:0] F_NORM      = 6'b011000;
    localparam logic [5:0] F_STALL     = 6'b100010;
    localparam logic [5:0] F_BR        = 6'b011110;
    localparam logic [5:0] F_HOLD      = 6'b000010;
    localparam logic [5:0] F_HALTED    = 6'b000011;
    localparam logic [5:0] F_RST       = 6'b000110;
    localparam logic [5:0] F_RST_STALL = 6'b100110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t a_in;
    in_t b_in;
    logic a_stall, a_pc_wen, a_ifid_wen, a_ifid_flush, a_bubble, a_halted;
    logic b_stall, b_pc_wen, b_ifid_wen, b_ifid_flush, b_bubble, b_halted;
    logic [15:0] a_sc, a_fe, b_sc, b_fe;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   n_chk  = 0;
    int   n_fail = 0;

    hazard_ctrl #(.WB_BYPASS(1'b1), .R0_ZERO(1'b1)) u_dut_a (
        .clk(clk), .rst(a_in.rst), .id_valid(a_in.id_valid),
        .id_raddr1(a_in.raddr1), .id_raddr1_used(a_in.used1),
        .id_raddr2(a_in.raddr2), .id_raddr2_used(a_in.used2),
        .id_reg_wen(a_in.wen), .id_waddr(a_in.waddr),
        .branch_taken(a_in.bt), .dbg_halt(a_in.halt),
        .pc_wen(a_pc_wen), .ifid_wen(a_ifid_wen), .ifid_flush(a_ifid_flush),
        .idexe_bubble(a_bubble), .stall(a_stall), .halted(a_halted),
        .stall_cycles(a_sc), .flush_events(a_fe)
    );

    hazard_ctrl #(.WB_BYPASS(1'b0), .R0_ZERO(1'b1)) u_dut_b (
        .clk(clk), .rst(b_in.rst), .id_valid(b_in.id_valid),
        .id_raddr1(b_in.raddr1), .id_raddr1_used(b_in.used1),
        .id_raddr2(b_in.raddr2), .id_raddr2_used(b_in.used2),
        .id_reg_wen(b_in.wen), .id_waddr(b_in.waddr),
        .branch_taken(b_in.bt), .dbg_halt(b_in.halt),
        .pc_wen(b_pc_wen), .ifid_wen(b_ifid_wen), .ifid_flush(b_ifid_flush),
        .idexe_bubble(b_bubble), .stall(b_stall), .halted(b_halted),
        .stall_cycles(b_sc), .flush_events(b_fe)
    );

    function automatic in_t mk(input logic r, input logic v,
                               input logic [3:0] a1, input logic u1,
                               input logic [3:0] a2, input logic u2,
                               input logic w, input logic [3:0] wa,
                               input logic bt, input logic h);
        in_t t;
        t.rst = r; t.id_valid = v; t.raddr1 = a1; t.used1 = u1;
        t.raddr2 = a2; t.used2 = u2; t.wen = w; t.waddr = wa;
        t.bt = bt; t.halt = h;
        return t;
    endfunction

    function automatic exp_t mke(input string n, input logic [5:0] f,
                                 input logic [15:0] sc, input logic [15:0] fe);
        exp_t e;
        e.name = n; e.flags = f; e.sc = sc; e.fe = fe;
        return e;
    endfunction

    task automatic step_a(input in_t v, input bit chk, input string n,
                          input logic [5:0] f, input logic [15:0] sc, input logic [15:0] fe);
        @(posedge clk);
        #1;
        a_in = v;
        if (chk) qa.push_back(mke(n, f, sc, fe));
    endtask

    task automatic step_b(input in_t v, input bit chk, input string n,
                          input logic [5:0] f, input logic [15:0] sc, input logic [15:0] fe);
        @(posedge clk);
        #1;
        b_in = v;
        if (chk) qb.push_back(mke(n, f, sc, fe));
    endtask

    // Monitor: outputs are present every cycle; compare mid-cycle whenever a response is expected.
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            n_chk++;
            if ({a_stall, a_pc_wen, a_ifid_wen, a_ifid_flush, a_bubble, a_halted} !== ea.flags ||
                a_sc !== ea.sc || a_fe !== ea.fe) begin
                n_fail++;
                $display("FAIL A.%s: got flags=%b stall_cycles=%h flush_events=%h, expected flags=%b stall_cycles=%h flush_events=%h",
                         ea.name, {a_stall, a_pc_wen, a_ifid_wen, a_ifid_flush, a_bubble, a_halted},
                         a_sc, a_fe, ea.flags, ea.sc, ea.fe);
            end
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            n_chk++;
            if ({b_stall, b_pc_wen, b_ifid_wen, b_ifid_flush, b_bubble, b_halted} !== eb.flags ||
                b_sc !== eb.sc || b_fe !== eb.fe) begin
                n_fail++;
                $display("FAIL B.%s: got flags=%b stall_cycles=%h flush_events=%h, expected flags=%b stall_cycles=%h flush_events=%h",
                         eb.name, {b_stall, b_pc_wen, b_ifid_wen, b_ifid_flush, b_bubble, b_halted},
                         b_sc, b_fe, eb.flags, eb.sc, eb.fe);
            end
        end
    end

    // Watchdog: the run is bounded even if a thread misbehaves.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        a_in = mk(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        b_in = mk(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        fork
            begin : thread_a
                in_t cons;
                step_a(mk(1,0,0,0,0,0,0,0,0,0), 1'b1, "reset_state", F_RST, 16'd0, 16'd0);
                // producer add r3 then dependent add r4,r3,r1: two stall cycles
                step_a(mk(0,1,4'd1,1,4'd2,1,1,4'd3,0,0), 1'b1, "producer_r3", F_NORM, 16'd0, 16'd0);
                cons = mk(0,1,4'd3,1,4'd1,1,1,4'd4,0,0);
                step_a(cons, 1'b1, "raw_exe_stall", F_STALL, 16'd0, 16'd0);
                step_a(cons, 1'b1, "raw_mem_stall", F_STALL, 16'd1, 16'd0);
                step_a(cons, 1'b1, "wb_bypass_issue", F_NORM, 16'd2, 16'd0);
                // register 0 never hazards, unused sources never hazard, wen=0 entries never hazard
                step_a(mk(0,1,4'd0,1,4'd0,1,1,4'd0,0,0), 1'b1, "write_r0", F_NORM, 16'd2, 16'd0);
                step_a(mk(0,1,4'd0,1,4'd4,0,1,4'd5,0,0), 1'b1, "read_r0_no_stall", F_NORM, 16'd2, 16'd0);
                step_a(mk(0,1,4'd5,0,4'd5,0,1,4'd6,0,0), 1'b1, "unused_src_no_stall", F_NORM, 16'd2, 16'd0);
                step_a(mk(0,1,4'd0,0,4'd0,0,0,4'd7,0,0), 1'b1, "store_no_wen", F_NORM, 16'd2, 16'd0);
                step_a(mk(0,1,4'd7,1,4'd0,1,1,4'd8,0,0), 1'b1, "wen0_entry_no_stall", F_NORM, 16'd2, 16'd0);
                // taken branch with a RAW hazard in ID: branch wins, no stall counted
                step_a(mk(0,1,4'd8,1,4'd0,0,1,4'd9,1,0), 1'b1, "branch_over_raw", F_BR, 16'd2, 16'd0);
                step_a(mk(0,0,4'd0,0,4'd0,0,0,4'd0,0,0), 1'b1, "after_branch", F_NORM, 16'd2, 16'd1);
                step_a(mk(0,1,4'd0,0,4'd0,0,1,4'd1,1,0), 1'b1, "branch_plain", F_BR, 16'd2, 16'd1);
                step_a(mk(0,0,4'd0,0,4'd0,0,0,4'd0,0,0), 1'b1, "after_branch2", F_NORM, 16'd2, 16'd2);
                // three independent instructions in flight, then debug halt drains
                step_a(mk(0,1,4'd0,0,4'd0,0,1,4'd9,0,0),  1'b1, "fill_r9",  F_NORM, 16'd2, 16'd2);
                step_a(mk(0,1,4'd0,0,4'd0,0,1,4'd10,0,0), 1'b1, "fill_r10", F_NORM, 16'd2, 16'd2);
                step_a(mk(0,1,4'd0,0,4'd0,0,1,4'd11,0,0), 1'b1, "fill_r11", F_NORM, 16'd2, 16'd2);
                step_a(mk(0,1,4'd0,0,4'd0,0,1,4'd12,0,1), 1'b1, "halt_drain1", F_HOLD, 16'd2, 16'd2);
                step_a(mk(0,1,4'd0,0,4'd0,0,1,4'd12,0,1), 1'b1, "halt_drain2", F_HOLD, 16'd2, 16'd2);
                step_a(mk(0,1,4'd0,0,4'd0,0,1,4'd12,0,1), 1'b1, "halt_drain3", F_HOLD, 16'd2, 16'd2);
                step_a(mk(0,1,4'd0,0,4'd0,0,1,4'd12,0,1), 1'b1, "halted_rise", F_HALTED, 16'd2, 16'd2);
                step_a(mk(0,1,4'd0,0,4'd0,0,1,4'd12,0,1), 1'b1, "halted_hold", F_HALTED, 16'd2, 16'd2);
                step_a(mk(0,1,4'd0,0,4'd0,0,1,4'd12,0,0), 1'b1, "halt_resume", F_NORM, 16'd2, 16'd2);
                // reset in the middle of a stall discards everything
                cons = mk(0,1,4'd12,1,4'd0,0,1,4'd13,0,0);
                step_a(cons, 1'b1, "stall_before_rst", F_STALL, 16'd2, 16'd2);
                cons.rst = 1'b1;
                step_a(cons, 1'b1, "rst_during_stall", F_RST_STALL, 16'd3, 16'd2);
                cons.rst = 1'b0;
                step_a(cons, 1'b1, "first_after_rst", F_NORM, 16'd0, 16'd0);
                step_a(mk(0,0,4'd0,0,4'd0,0,0,4'd0,0,0), 1'b0, "", F_NORM, 16'd0, 16'd0);
            end
            begin : thread_b
                in_t cons;
                step_b(mk(1,0,0,0,0,0,0,0,0,0), 1'b1, "reset_state", F_RST, 16'd0, 16'd0);
                step_b(mk(0,1,4'd1,1,4'd2,1,1,4'd3,0,0), 1'b1, "producer_r3", F_NORM, 16'd0, 16'd0);
                cons = mk(0,1,4'd3,1,4'd1,1,1,4'd4,0,0);
                step_b(cons, 1'b1, "nb_stall1", F_STALL, 16'd0, 16'd0);
                step_b(cons, 1'b1, "nb_stall2", F_STALL, 16'd1, 16'd0);
                step_b(cons, 1'b1, "nb_stall3_wb", F_STALL, 16'd2, 16'd0);
                step_b(cons, 1'b1, "nb_issue", F_NORM, 16'd3, 16'd0);
                // self-dependent instruction: issue, 3 stalls, repeat -> counter saturates
                step_b(mk(0,1,4'd5,1,4'd0,0,1,4'd5,0,0), 1'b0, "", F_NORM, 16'd0, 16'd0);
                repeat (87400) @(posedge clk);
                step_b(mk(0,0,4'd0,0,4'd0,0,0,4'd0,0,0), 1'b0, "", F_NORM, 16'd0, 16'd0);
                step_b(mk(0,0,4'd0,0,4'd0,0,0,4'd0,0,0), 1'b0, "", F_NORM, 16'd0, 16'd0);
                step_b(mk(0,0,4'd0,0,4'd0,0,0,4'd0,0,0), 1'b0, "", F_NORM, 16'd0, 16'd0);
                step_b(mk(0,0,4'd0,0,4'd0,0,0,4'd0,0,0), 1'b1, "saturated", F_NORM, 16'hFFFF, 16'd0);
                step_b(mk(0,1,4'd1,1,4'd2,1,1,4'd3,0,0), 1'b1, "sat_producer", F_NORM, 16'hFFFF, 16'd0);
                step_b(cons, 1'b1, "sat_stall1", F_STALL, 16'hFFFF, 16'd0);
                step_b(cons, 1'b1, "sat_stall2", F_STALL, 16'hFFFF, 16'd0);
                step_b(cons, 1'b1, "sat_stall3", F_STALL, 16'hFFFF, 16'd0);
                step_b(cons, 1'b1, "sat_hold", F_NORM, 16'hFFFF, 16'd0);
                step_b(mk(0,0,4'd0,0,4'd0,0,0,4'd0,0,0), 1'b0, "", F_NORM, 16'd0, 16'd0);
            end
        join
        repeat (3) @(posedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
